// File: rtl/core_lsu_axil_pkg.sv
// core_lsu_pkg: size/response encodings and FSM states for the AXI4-Lite load/store unit
package core_lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, RESP} lsu_state_e;
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    return (sz == SZ_BYTE) ? 4'h1 : (sz == SZ_HALF) ? 4'h3 : (sz == SZ_WORD) ? 4'hF : 4'h0;
  endfunction
endpackage

// File: rtl/core_lsu_axil_if.sv
// core_lsu_axil_if: AXI4-Lite bus bundle with master/slave views
interface core_lsu_axil_if #(parameter int AXI_AWIDTH = 32, parameter int AXI_DWIDTH = 32);
  logic [AXI_AWIDTH-1:0] AXI_AWADDR;
  logic [2:0] AXI_AWPROT;
  logic AXI_AWVALID, AXI_AWREADY;
  logic [AXI_DWIDTH-1:0] AXI_WDATA;
  logic [AXI_DWIDTH/8-1:0] AXI_WSTRB;
  logic AXI_WVALID, AXI_WREADY;
  logic [1:0] AXI_BRESP;
  logic AXI_BVALID, AXI_BREADY;
  logic [AXI_AWIDTH-1:0] AXI_ARADDR;
  logic [2:0] AXI_ARPROT;
  logic AXI_ARVALID, AXI_ARREADY;
  logic [AXI_DWIDTH-1:0] AXI_RDATA;
  logic [1:0] AXI_RRESP;
  logic AXI_RVALID, AXI_RREADY;
  modport master (
    output AXI_AWADDR, AXI_AWPROT, AXI_AWVALID, AXI_WDATA, AXI_WSTRB, AXI_WVALID, AXI_BREADY,
    output AXI_ARADDR, AXI_ARPROT, AXI_ARVALID, AXI_RREADY,
    input AXI_AWREADY, AXI_WREADY, AXI_BRESP, AXI_BVALID, AXI_ARREADY, AXI_RDATA, AXI_RRESP, AXI_RVALID
  );
  modport slave (
    input AXI_AWADDR, AXI_AWPROT, AXI_AWVALID, AXI_WDATA, AXI_WSTRB, AXI_WVALID, AXI_BREADY,
    input AXI_ARADDR, AXI_ARPROT, AXI_ARVALID, AXI_RREADY,
    output AXI_AWREADY, AXI_WREADY, AXI_BRESP, AXI_BVALID, AXI_ARREADY, AXI_RDATA, AXI_RRESP, AXI_RVALID
  );
endinterface

// File: rtl/core_lsu_axil_lane.sv
// core_lsu_lane: byte-lane strobe/data placement for stores and extraction/extension for loads
module core_lsu_lane
  import core_lsu_pkg::*;
#(
  parameter int AXI_DWIDTH = 32,
  parameter int XLEN = 32
) (
  input  logic [$clog2(AXI_DWIDTH/8)-1:0] off,
  input  logic [1:0]                      size,
  input  logic                            sgn,
  input  logic [XLEN-1:0]                 st_data,
  input  logic [AXI_DWIDTH-1:0]           ld_bus,
  output logic [AXI_DWIDTH/8-1:0]         wstrb,
  output logic [AXI_DWIDTH-1:0]           wdata,
  output logic [XLEN-1:0]                 ld_data
);
  localparam int SW = AXI_DWIDTH / 8;
  logic [AXI_DWIDTH-1:0] shifted;
  // Size-wise replication already puts the store data on every lane the strobe can select,
  // so the shift by 8*off is absorbed and the whole bus carries the pattern.
  always_comb begin
    wstrb = SW'(size_mask(size)) << off;
    wdata = (size == SZ_BYTE) ? {SW{st_data[7:0]}} :
            (size == SZ_HALF) ? {(SW/2){st_data[15:0]}} : {(AXI_DWIDTH/32){st_data[31:0]}};
    shifted = ld_bus >> {off, 3'b000};
    ld_data = (size == SZ_BYTE) ? {{(XLEN-8){sgn & shifted[7]}}, shifted[7:0]} :
              (size == SZ_HALF) ? {{(XLEN-16){sgn & shifted[15]}}, shifted[15:0]} : shifted[XLEN-1:0];
  end
endmodule

// File: rtl/core_lsu_axil.sv
// core_lsu_axil: RV32I memory-stage load/store unit driving one AXI4-Lite transaction per request.
// Optional LSU_MISALIGN_TRAP_EN: misaligned requests return an error instead of being aligned down.
module core_lsu_axil
  import core_lsu_pkg::*;
#(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32,
  parameter int XLEN = 32
) (
  input  logic                  CLK,
  input  logic                  NRST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WE,
  input  logic [1:0]            REQ_SIZE,
  input  logic                  REQ_SIGNED,
  input  logic [AXI_AWIDTH-1:0] REQ_ADDR,
  input  logic [XLEN-1:0]       REQ_WDATA,
  output logic                  RSP_VALID,
  output logic [XLEN-1:0]       RSP_RDATA,
  output logic                  RSP_ERR,
  core_lsu_axil_if.master       axi
);
  localparam int OW = $clog2(AXI_DWIDTH/8);
  lsu_state_e state_q, state_d;
  logic [AXI_AWIDTH-1:0] addr_q, addr_d, amask;
  logic [1:0] size_q, size_d;
  logic signed_q, signed_d, we_q, we_d, err_q, err_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [XLEN-1:0] wdata_q, wdata_d, ld_data;
  logic [AXI_DWIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_q <= IDLE;
      addr_q <= '0;
      size_q <= '0;
      signed_q <= 1'b0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      size_q <= size_d;
      signed_q <= signed_d;
      we_q <= we_d;
      err_q <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    size_d = size_q;
    signed_d = signed_q;
    we_d = we_q;
    err_d = err_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    amask = (REQ_SIZE == SZ_HALF) ? AXI_AWIDTH'(1) : (REQ_SIZE == SZ_WORD) ? AXI_AWIDTH'(3) : '0;
    aw_done_d = aw_done_q | (axi.AXI_AWVALID & axi.AXI_AWREADY);
    w_done_d = w_done_q | (axi.AXI_WVALID & axi.AXI_WREADY);
    case (state_q)
      IDLE: if (REQ_VALID) begin
        addr_d = REQ_ADDR & ~amask;
        size_d = REQ_SIZE;
        signed_d = REQ_SIGNED;
        we_d = REQ_WE;
        wdata_d = REQ_WDATA;
        rdata_d = '0;
        err_d = 1'b0;
        aw_done_d = 1'b0;
        w_done_d = 1'b0;
        state_d = REQ_WE ? WR : RD_ADDR;
`ifdef LSU_MISALIGN_TRAP_EN
        if (|(REQ_ADDR & amask)) begin
          state_d = RESP;
          err_d = 1'b1;
        end
`endif
        if (REQ_SIZE == 2'b11) begin
          state_d = RESP;
          err_d = 1'b1;
        end
      end
      RD_ADDR: if (axi.AXI_ARREADY) begin
        state_d = axi.AXI_RVALID ? RESP : RD_DATA;
        rdata_d = axi.AXI_RVALID ? axi.AXI_RDATA : rdata_q;
        err_d = axi.AXI_RVALID & (axi.AXI_RRESP != RESP_OKAY);
      end
      RD_DATA: if (axi.AXI_RVALID) begin
        state_d = RESP;
        rdata_d = axi.AXI_RDATA;
        err_d = axi.AXI_RRESP != RESP_OKAY;
      end
      WR: state_d = (aw_done_d && w_done_d) ? WR_RESP : WR;
      WR_RESP: if (axi.AXI_BVALID) begin
        state_d = RESP;
        err_d = axi.AXI_BRESP != RESP_OKAY;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  core_lsu_lane #(.AXI_DWIDTH(AXI_DWIDTH), .XLEN(XLEN)) u_lane (
    .off(addr_q[OW-1:0]),
    .size(size_q),
    .sgn(signed_q),
    .st_data(wdata_q),
    .ld_bus(rdata_q),
    .wstrb(axi.AXI_WSTRB),
    .wdata(axi.AXI_WDATA),
    .ld_data(ld_data)
  );

  assign REQ_READY = state_q == IDLE;
  assign RSP_VALID = state_q == RESP;
  assign RSP_ERR = RSP_VALID & err_q;
  assign RSP_RDATA = (RSP_VALID && !err_q && !we_q) ? ld_data : '0;
  assign axi.AXI_ARADDR = addr_q;
  assign axi.AXI_AWADDR = addr_q;
  assign axi.AXI_ARPROT = 3'b000;
  assign axi.AXI_AWPROT = 3'b000;
  assign axi.AXI_ARVALID = state_q == RD_ADDR;
  assign axi.AXI_RREADY = (state_q == RD_ADDR) || (state_q == RD_DATA);
  assign axi.AXI_AWVALID = (state_q == WR) && !aw_done_q;
  assign axi.AXI_WVALID = (state_q == WR) && !w_done_q;
  assign axi.AXI_BREADY = (state_q == WR) || (state_q == WR_RESP);
endmodule

// File: tb/tb_core_lsu_axil.sv
// tb_core_lsu_axil: directed and randomized checks of core_lsu_axil against a delay-programmable AXI-Lite slave
module tb_core_lsu_axil;
  logic CLK = 1'b0, NRST = 1'b0;
  logic REQ_VALID = 1'b0, REQ_WE = 1'b0, REQ_SIGNED = 1'b0;
  logic [1:0] REQ_SIZE = 2'b00;
  logic [31:0] REQ_ADDR = '0, REQ_WDATA = '0;
  logic REQ_READY, RSP_VALID, RSP_ERR;
  logic [31:0] RSP_RDATA;
  int n_cmp = 0, n_fail = 0;

  core_lsu_axil_if #(.AXI_AWIDTH(32), .AXI_DWIDTH(32)) axi();

  core_lsu_axil #(.AXI_AWIDTH(32), .AXI_DWIDTH(32), .XLEN(32)) dut (
    .CLK(CLK), .NRST(NRST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_SIZE(REQ_SIZE), .REQ_SIGNED(REQ_SIGNED), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .axi(axi)
  );

  always #5 CLK = ~CLK;

  // slave: READY/response delays programmed per transaction, handshakes logged in free-running counters
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0] s_rresp = 2'b00, s_bresp = 2'b00;
  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic r_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, aw_now, w_now;
  int ar_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0, awv_cyc = 0, wv_cyc = 0;
  logic [31:0] last_araddr = '0, last_awaddr = '0, last_wdata = '0;
  logic [3:0] last_wstrb = '0;

  assign axi.AXI_ARREADY = axi.AXI_ARVALID && ar_wait >= ar_dly;
  assign axi.AXI_RVALID = (r_pend && r_wait >= r_dly) || (axi.AXI_ARVALID && axi.AXI_ARREADY && r_dly == 0);
  assign axi.AXI_RDATA = s_rdata;
  assign axi.AXI_RRESP = s_rresp;
  assign axi.AXI_AWREADY = axi.AXI_AWVALID && aw_wait >= aw_dly;
  assign axi.AXI_WREADY = axi.AXI_WVALID && w_wait >= w_dly;
  assign axi.AXI_BVALID = b_pend && b_wait >= b_dly;
  assign axi.AXI_BRESP = s_bresp;
  assign aw_now = aw_got | (axi.AXI_AWVALID & axi.AXI_AWREADY);
  assign w_now = w_got | (axi.AXI_WVALID & axi.AXI_WREADY);

  always @(posedge CLK) begin
    if (!NRST) begin
      ar_wait <= 0; r_wait <= 0; r_pend <= 1'b0; aw_wait <= 0; w_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; b_wait <= 0;
    end else begin
      ar_wait <= (axi.AXI_ARVALID && !axi.AXI_ARREADY) ? ar_wait + 1 : 0;
      aw_wait <= (axi.AXI_AWVALID && !axi.AXI_AWREADY) ? aw_wait + 1 : 0;
      w_wait <= (axi.AXI_WVALID && !axi.AXI_WREADY) ? w_wait + 1 : 0;
      if (axi.AXI_RVALID && axi.AXI_RREADY) r_pend <= 1'b0;
      else if (axi.AXI_ARVALID && axi.AXI_ARREADY) begin r_pend <= 1'b1; r_wait <= 1; end
      else if (r_pend) r_wait <= r_wait + 1;
      if (aw_now && w_now) begin b_pend <= 1'b1; b_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0; end
      else begin aw_got <= aw_now; w_got <= w_now; end
      if (axi.AXI_BVALID && axi.AXI_BREADY) b_pend <= 1'b0;
      else if (b_pend) b_wait <= b_wait + 1;
    end
    if (axi.AXI_ARVALID && axi.AXI_ARREADY) begin ar_hs <= ar_hs + 1; last_araddr <= axi.AXI_ARADDR; end
    if (axi.AXI_AWVALID && axi.AXI_AWREADY) begin aw_hs <= aw_hs + 1; last_awaddr <= axi.AXI_AWADDR; end
    if (axi.AXI_WVALID && axi.AXI_WREADY) begin w_hs <= w_hs + 1; last_wdata <= axi.AXI_WDATA; last_wstrb <= axi.AXI_WSTRB; end
    if (axi.AXI_BVALID && axi.AXI_BREADY) b_hs <= b_hs + 1;
    awv_cyc <= awv_cyc + int'(axi.AXI_AWVALID);
    wv_cyc <= wv_cyc + int'(axi.AXI_WVALID);
  end

  // reference: load result from the bus word using plain arithmetic on byte offsets
  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] ad, input logic [31:0] bus);
    longint nb, off, v;
    nb = longint'(1) << sz;
    off = longint'(ad % 4);
    off = off - off % nb;
    v = (longint'(bus) >> (8 * off)) % (longint'(1) << (8 * nb));
    if (sg && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] ad, input logic [31:0] wd,
                        output logic got, output logic [31:0] rd, output logic er, output int cyc);
    @(negedge CLK);
    for (int i = 0; i < 100 && !REQ_READY; i++) @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WE = we; REQ_SIZE = sz; REQ_SIGNED = sg; REQ_ADDR = ad; REQ_WDATA = wd;
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
    got = 1'b0; rd = '0; er = 1'b0; cyc = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge CLK);
      cyc++;
      if (RSP_VALID) begin got = 1'b1; rd = RSP_RDATA; er = RSP_ERR; end
    end
  endtask

  task automatic test_reset();
    logic [7:0] ctl;
    NRST = 1'b0;
    repeat (3) @(negedge CLK);
    ctl = {REQ_READY, RSP_VALID, RSP_ERR, axi.AXI_ARVALID, axi.AXI_RREADY, axi.AXI_AWVALID, axi.AXI_WVALID, axi.AXI_BREADY};
    n_cmp++; if (ctl !== 8'b1000_0000) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, 8'b1000_0000); end
    n_cmp++; if (RSP_RDATA !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", RSP_RDATA); end
    NRST = 1'b1;
  endtask

  task automatic test_lw_fast();
    logic got, er; logic [31:0] rd; int cyc, a0;
    ar_dly = 0; r_dly = 0; s_rdata = 32'hDEADBEEF; s_rresp = 2'b00; a0 = ar_hs;
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, got, rd, er, cyc);
    n_cmp++; if (cyc !== 2 || !got) begin n_fail++; $display("FAIL lw_latency: got %0d cycles (valid=%b) want 2", cyc, got); end
    n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_fail++; $display("FAIL lw_data: got %h err %b want deadbeef err 0", rd, er); end
    n_cmp++; if (ar_hs - a0 !== 1 || last_araddr !== 32'h100) begin n_fail++; $display("FAIL lw_ar: got %0d hs addr %h want 1 hs addr 100", ar_hs - a0, last_araddr); end
    @(negedge CLK);
    n_cmp++; if (RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL lw_pulse: got RSP_VALID %b want 0", RSP_VALID); end
  endtask

  task automatic test_lb_lhu();
    logic got, er; logic [31:0] rd; int cyc;
    ar_dly = 1; r_dly = 2; s_rdata = 32'h80FF1234; s_rresp = 2'b00;
    do_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, got, rd, er, cyc);
    n_cmp++; if (rd !== 32'hFFFFFF80 || er !== 1'b0 || !got) begin n_fail++; $display("FAIL lb_signed: got %h err %b want ffffff80 err 0", rd, er); end
    do_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, got, rd, er, cyc);
    n_cmp++; if (rd !== 32'h000080FF || er !== 1'b0 || !got) begin n_fail++; $display("FAIL lhu: got %h err %b want 000080ff err 0", rd, er); end
    ar_dly = 0; r_dly = 0;
  endtask

  task automatic test_sb_delay();
    logic got, er; logic [31:0] rd; int cyc, aw0, w0, av0, wv0, b0;
    aw_dly = 3; w_dly = 0; b_dly = 0; s_bresp = 2'b00;
    aw0 = aw_hs; w0 = w_hs; av0 = awv_cyc; wv0 = wv_cyc; b0 = b_hs;
    do_req(1'b1, 2'b00, 1'b0, 32'h101, 32'h000000A5, got, rd, er, cyc);
    n_cmp++; if (last_wstrb !== 4'h2 || last_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_lanes: got strb %h data %h want 2 a5a5a5a5", last_wstrb, last_wdata); end
    n_cmp++; if (awv_cyc - av0 !== 4 || wv_cyc - wv0 !== 1) begin n_fail++; $display("FAIL sb_valid_cycles: got aw %0d w %0d want aw 4 w 1", awv_cyc - av0, wv_cyc - wv0); end
    n_cmp++; if (aw_hs - aw0 !== 1 || w_hs - w0 !== 1 || b_hs - b0 !== 1 || last_awaddr !== 32'h101) begin n_fail++; $display("FAIL sb_handshakes: got aw %0d w %0d b %0d addr %h want 1 1 1 101", aw_hs - aw0, w_hs - w0, b_hs - b0, last_awaddr); end
    n_cmp++; if (!got || er !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL sb_rsp: got valid %b err %b data %h want 1 0 0", got, er, rd); end
    @(negedge CLK);
    n_cmp++; if (RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL sb_single_rsp: got RSP_VALID %b want 0", RSP_VALID); end
    aw_dly = 0;
  endtask

  task automatic test_errors();
    logic got, er; logic [31:0] rd; int cyc, b0;
    s_rdata = 32'h12345678; s_rresp = 2'b10;
    do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, got, rd, er, cyc);
    n_cmp++; if (!got || er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL lw_slverr: got valid %b err %b data %h want 1 1 0", got, er, rd); end
    s_rresp = 2'b00; s_bresp = 2'b11; b0 = b_hs;
    do_req(1'b1, 2'b10, 1'b0, 32'h204, 32'h55AA55AA, got, rd, er, cyc);
    n_cmp++; if (!got || er !== 1'b1 || b_hs - b0 !== 1) begin n_fail++; $display("FAIL sw_decerr: got valid %b err %b bhs %0d want 1 1 1", got, er, b_hs - b0); end
    s_bresp = 2'b00;
  endtask

  task automatic test_reserved_size();
    logic got, er; logic [31:0] rd; int cyc, a0, aw0;
    a0 = ar_hs; aw0 = aw_hs;
    do_req(1'b0, 2'b11, 1'b0, 32'h300, 32'h0, got, rd, er, cyc);
    n_cmp++; if (!got || cyc !== 1 || er !== 1'b1 || ar_hs !== a0) begin n_fail++; $display("FAIL rsvd_load: got cyc %0d err %b ar %0d want 1 1 0", cyc, er, ar_hs - a0); end
    do_req(1'b1, 2'b11, 1'b0, 32'h300, 32'h0, got, rd, er, cyc);
    n_cmp++; if (!got || er !== 1'b1 || aw_hs !== aw0) begin n_fail++; $display("FAIL rsvd_store: got err %b aw %0d want 1 0", er, aw_hs - aw0); end
  endtask

  task automatic test_misalign();
    logic got, er; logic [31:0] rd; int cyc, a0;
    s_rdata = 32'hCAFEF00D; s_rresp = 2'b00; a0 = ar_hs;
    do_req(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, got, rd, er, cyc);
`ifdef LSU_MISALIGN_TRAP_EN
    n_cmp++; if (!got || cyc !== 1 || er !== 1'b1 || ar_hs !== a0) begin n_fail++; $display("FAIL misalign_trap: got cyc %0d err %b ar %0d want 1 1 0", cyc, er, ar_hs - a0); end
`else
    n_cmp++; if (!got || er !== 1'b0 || rd !== 32'hCAFEF00D || last_araddr !== 32'h100 || ar_hs - a0 !== 1) begin n_fail++; $display("FAIL misalign_align: got err %b data %h addr %h want 0 cafef00d 100", er, rd, last_araddr); end
`endif
  endtask

  task automatic test_reset_mid();
    logic seen; logic [3:0] ctl;
    ar_dly = 0; r_dly = 30; s_rresp = 2'b00;
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_SIZE = 2'b10; REQ_ADDR = 32'h400;
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++; if (axi.AXI_RREADY !== 1'b1 || axi.AXI_ARVALID !== 1'b0) begin n_fail++; $display("FAIL mid_rd_data: got rready %b arvalid %b want 1 0", axi.AXI_RREADY, axi.AXI_ARVALID); end
    NRST = 1'b0;
    @(negedge CLK);
    ctl = {axi.AXI_ARVALID, axi.AXI_RREADY, REQ_READY, RSP_VALID};
    n_cmp++; if (ctl !== 4'b0010) begin n_fail++; $display("FAIL mid_reset: got ar/rr/ready/rsp %b want 0010", ctl); end
    NRST = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(negedge CLK); seen |= RSP_VALID; end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp: got RSP_VALID seen %b want 0", seen); end
    r_dly = 0;
  endtask

  task automatic test_random();
    logic got, er, we, sg, mis, traffic, e_er; logic [1:0] sz; logic [31:0] ad, wd, rd, e_rd, e_addr, e_data, lmask;
    logic [3:0] e_strb; int cyc, a0, aw0, w0, nb, off;
    for (int t = 0; t < 200; t++) begin
      we = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      ad = 32'h1000 + 32'($urandom_range(0, 255)); wd = $urandom; s_rdata = $urandom;
      s_rresp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      s_bresp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      nb = 1 << sz; off = int'(ad % 4); off = off - off % nb; mis = (ad % nb) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
      traffic = sz != 2'b11 && !mis;
`else
      traffic = sz != 2'b11;
`endif
      e_er = !traffic || (we ? s_bresp != 2'b00 : s_rresp != 2'b00);
      e_rd = (e_er || we) ? 32'h0 : ref_load(sz, sg, ad, s_rdata);
      e_addr = ad - ad % nb;
      e_strb = 4'(((1 << nb) - 1) << off);
      lmask = '0;
      for (int i = 0; i < 4; i++) if (e_strb[i]) lmask[8*i +: 8] = 8'hFF;
      e_data = (wd << (8 * off)) & lmask;
      a0 = ar_hs; aw0 = aw_hs; w0 = w_hs;
      do_req(we, sz, sg, ad, wd, got, rd, er, cyc);
      n_cmp++; if (!got) begin n_fail++; $display("FAIL rnd_timeout[%0d]: no response within %0d cycles", t, cyc); end
      n_cmp++; if (er !== e_er || rd !== e_rd) begin n_fail++; $display("FAIL rnd_rsp[%0d]: we %b sz %0d addr %h got %h/%b want %h/%b", t, we, sz, ad, rd, er, e_rd, e_er); end
      n_cmp++; if (ar_hs - a0 !== int'(traffic && !we) || aw_hs - aw0 !== int'(traffic && we) || w_hs - w0 !== int'(traffic && we)) begin
        n_fail++; $display("FAIL rnd_traffic[%0d]: got ar %0d aw %0d w %0d want traffic %b we %b", t, ar_hs - a0, aw_hs - aw0, w_hs - w0, traffic, we); end
      if (traffic && !we) begin
        n_cmp++; if (last_araddr !== e_addr) begin n_fail++; $display("FAIL rnd_araddr[%0d]: got %h want %h", t, last_araddr, e_addr); end
      end
      if (traffic && we) begin
        n_cmp++; if (last_awaddr !== e_addr || last_wstrb !== e_strb || (last_wdata & lmask) !== e_data) begin
          n_fail++; $display("FAIL rnd_write[%0d]: got addr %h strb %h data %h want %h %h %h", t, last_awaddr, last_wstrb, last_wdata & lmask, e_addr, e_strb, e_data); end
      end
    end
    s_rresp = 2'b00; s_bresp = 2'b00;
  endtask

  initial begin
    test_reset();
    test_lw_fast();
    test_lb_lhu();
    test_sb_delay();
    test_errors();
    test_reserved_size();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/core_lsu_axil.md
Name: core_lsu_axil

Overview:
AXI4-Lite load/store unit for the RV32I pipeline memory stage.
- Accepts one load or store per request handshake and runs a full AXI-Lite transaction: AR/R for loads, AW/W/B for stores.
- Returns one response with sign/zero-extended load data or an error flag.
- Data bus width is parametrised (32 or 64); address width is generic; AXI handshakes are fully compliant (VALID held until READY).

Parameters:
AXI_AWIDTH  32  AXI address width; REQ_ADDR width.
AXI_DWIDTH  32  AXI data width, 32 or 64; strobe width AXI_DWIDTH/8.
XLEN  32  register data width of REQ_WDATA/RSP_RDATA.

Ports:
CLK  in  1  clock
NRST  in  1  reset
REQ_VALID  in  1  request valid
REQ_READY  out  1  high only in IDLE
REQ_WE  in  1  1=store, 0=load
REQ_SIZE  in  2  00 byte, 01 half, 10 word (11 reserved → error)
REQ_SIGNED  in  1  sign-extend load result
REQ_ADDR  in  AXI_AWIDTH  byte address
REQ_WDATA  in  XLEN  store data, LSB-aligned
RSP_VALID  out  1  one-cycle response pulse
RSP_RDATA  out  XLEN  extended load data; 0 for stores/errors
RSP_ERR  out  1  slave error, reserved size, or misalign (with macro)
AXI_AWADDR/AWVALID/AWREADY, AXI_WDATA/WSTRB/WVALID/WREADY, AXI_BRESP/BVALID/BREADY, AXI_ARADDR/ARVALID/ARREADY, AXI_RDATA/RRESP/RVALID/RREADY  standard AXI4-Lite master, widths from parameters; AWPROT/ARPROT tied 3'b000.

Behaviour:
- Clocking/reset: NRST is synchronous, active-low; clock is CLK.
- Reset values: all AXI VALID/READY 0, RSP_VALID 0, RSP_ERR 0, RSP_RDATA 0, state IDLE.
- Request capture:
  - Accepted when REQ_VALID & REQ_READY.
  - ADDR, SIZE, SIGNED, WE and WDATA are registered; outputs depend only on registered state.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, RESP.
- IDLE:
  - On accept: RD_ADDR if load, WR if store.
  - Reserved size: RESP with RSP_ERR=1, no AXI traffic.
- RD_ADDR:
  - ARVALID=1 and RREADY=1.
  - ARVALID drops on ARREADY.
  - Same-cycle ARREADY & RVALID is allowed: go straight to RESP. Otherwise go to RD_DATA.
- RD_DATA: RREADY=1 until RVALID; capture RDATA/RRESP; go to RESP.
- WR:
  - AWVALID and WVALID are driven independently, each dropping on its own READY (flags aw_done, w_done).
  - Move to WR_RESP when both are done, including same-cycle completion.
  - BREADY=1 from WR entry.
- WR_RESP: wait BVALID; capture BRESP; go to RESP.
- RESP: RSP_VALID=1 for exactly one cycle, then IDLE.
- Minimum latency with a zero-wait slave: accept at edge 0, ARVALID at edge 1, RSP_VALID at edge 2.
- Lane selection:
  - off = ADDR[log2(AXI_DWIDTH/8)-1:0].
  - WSTRB = size mask (0x1/0x3/0xF) << off.
  - WDATA = store data replicated across the bus, then shifted left by 8*off.
- AWADDR/ARADDR carry the full byte address.
- Load extraction:
  - Shift captured RDATA right by 8*off, mask to size.
  - Extend bit 7 or bit 15 when SIGNED; word loads are passed unchanged.
- Errors:
  - RRESP/BRESP != 00 → RSP_ERR=1 and RSP_RDATA=0.
  - A store error still counts as a completed bus transaction.
- Reset mid-transaction: next edge forces reset values and IDLE. The slave is reset by the same NRST.
- No outstanding-transaction overlap: one transaction at a time.

Optional Feature:
Macro LSU_MISALIGN_TRAP_EN.
- Defined: a request with addr not aligned to its size, or crossing the bus width, issues no AXI transaction. It goes IDLE→RESP with RSP_ERR=1 and RSP_VALID on the cycle after acceptance.
- Undefined: low address bits below the size are cleared (access aligned down) and the transaction proceeds normally.

Decomposition:
- Package core_lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - AXI response codes RESP_OKAY/SLVERR/DECERR;
  - the FSM state enum.
- Sub-module core_lsu_lane: combinational strobe/WDATA placement and load extraction/extension, parametrised on AXI_DWIDTH/XLEN.

Test Plan:
- LW at 0x100, slave returns RDATA=0xDEADBEEF with ARREADY=1/RVALID=1 same cycle → RSP_RDATA=0xDEADBEEF, RSP_ERR=0, RSP_VALID 2 cycles after accept.
- LB signed at 0x103, RDATA=0x80FF_1234 → 0xFFFFFF80. LHU at 0x102 with same data → 0x000080FF.
- SB 0xA5 at 0x101 with AWREADY delayed 3 cycles and WREADY immediate → WSTRB=0x2, WDATA=0xA5A5A5A5, WVALID drops after 1 cycle, AWVALID held 4 cycles, single RSP after BVALID.
- LW with RRESP=2'b10 → RSP_ERR=1, RSP_RDATA=0; SW with BRESP=2'b11 → RSP_ERR=1.
- NRST low while in RD_DATA → next cycle ARVALID=RREADY=0, REQ_READY=1, no RSP_VALID.
- LW at 0x102: with LSU_MISALIGN_TRAP_EN → no ARVALID, RSP_ERR=1 next cycle; without the macro → ARADDR=0x100, normal response.
